spi_mmio_bridge: RTL
====================

SPI_MMIO_BRIDGE -- requirements
Module: spi_mmio_bridge

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-003 SHALL have port spi_sclk, input, 1, SPI clock from the MCU, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-004 SHALL have port spi_cs_n, input, 1, SPI frame select, active-low, asynchronous.
REQ-005 SHALL have port spi_mosi, input, 1, serial data from the MCU, MSB first.
REQ-006 SHALL have port spi_miso, output, 1, serial data to the MCU, MSB first; 0 when the frame is inactive.
REQ-007 SHALL have port cs, output, 1, MMIO select, high only together with rd or wr.
REQ-008 SHALL have port rd, output, 1, MMIO read strobe, one clk cycle.
REQ-009 SHALL have port wr, output, 1, MMIO write strobe, one clk cycle.
REQ-010 SHALL have port addr, output, 8, MMIO address, {1'b0, addr7}.
REQ-011 SHALL have port wdata, output, 8, MMIO write data.
REQ-012 SHALL have port rdata, input, 8, MMIO read data; combinational, valid in the cycle cs&&rd is high.

Function
REQ-013 SHALL pass spi_sclk, spi_cs_n and spi_mosi each through a 2-flop synchronizer, then detect SCLK rise and fall edges with one further register stage; clk SHALL be at least 8x the SCLK frequency.
REQ-014 SHALL implement the FSM states IDLE, CMD and DATA, with these transitions:
- IDLE->CMD on the synced cs_n falling edge, clearing the bit counter.
- CMD->DATA after 8 bits are sampled.
- DATA->DATA after every further 8 bits.
- Any state->IDLE on synced cs_n high.
REQ-015 SHALL sample MOSI on each synced SCLK rise into an 8-bit shift register, using a 3-bit bit counter that wraps 7->0.
REQ-016 SHALL decode the command byte as [7]=RD (1 read, 0 write) and [6:0]=addr7.
REQ-017 SHALL handle writes as follows: in the cycle the 8th DATA bit is sampled (cycle N), register wdata; in cycle N+1 assert cs=wr=1 for exactly one cycle with the current addr.
REQ-018 SHALL handle reads as follows: one cycle after the 8th command bit is sampled, assert cs=rd=1 for one cycle and capture rdata into the tx shift register at the end of that cycle, so that spi_miso shows tx[7] from the next cycle.
REQ-019 SHALL shift tx left on each synced SCLK fall during DATA.
REQ-020 SHALL support bursts: after each completed DATA byte, addr7 SHALL increment modulo 128 (0x7F->0x00); for reads, the next byte SHALL be prefetched with a new rd pulse one cycle after that byte completes.
REQ-021 SHALL accept a write burst of any length, with one wr pulse per full byte.
REQ-022 SHALL treat cs_n rising mid-byte as an abort: discard the partial byte, issue no strobe, return to IDLE, and drive spi_miso=0 the next cycle.
REQ-023 SHALL ignore a frame with cs_n high before the command byte completes: no MMIO access.
REQ-024 SHALL never assert rd and wr in the same cycle, and SHALL NOT generate strobes in IDLE.
REQ-025 SHALL ignore SCLK edges while synced cs_n is high.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force:
- cs=0, rd=0, wr=0, addr=0x00, wdata=0x00, spi_miso=0;
- FSM=IDLE, bit counter=0, shift registers=0x00;
- synchronizer flops for cs_n to 1, for sclk and mosi to 0.
REQ-027 SHALL resume only on a fresh cs_n falling edge after rst_n is released; a frame in progress at reset SHALL be lost.

Structure
REQ-028 SHALL take the FSM state enum, RD_BIT index (7), ADDR_W (7) and SYNC_STAGES (2) from the shared package spi_mmio_pkg.
REQ-029 SHALL implement the synchronizer as a separate sub-module sync_2ff, instantiated three times.
REQ-030 SHALL keep all MMIO outputs registered, with no combinational path from SPI pins to the MMIO bus.

Verification
REQ-031 SHALL verify a single write: frame 0x02,0x35 -> exactly one wr pulse with addr=0x02, wdata=0x35, and no rd.
REQ-032 SHALL verify a burst write: frame 0x10,0x80,0x80,0xC0,0x00 -> four wr pulses at addr 0x10..0x13 carrying the data in order.
REQ-033 SHALL verify a single read: frame 0x84, dummy byte, with rdata=0x4B at addr 0x04 -> one rd pulse at addr 0x04 before the first data SCLK rise, and the MISO byte reads 0x4B.
REQ-034 SHALL verify wrap-around: burst write starting at 0x7F, 2 bytes -> wr at 0x7F then 0x00.
REQ-035 SHALL verify abort: cs_n raised after 5 bits of a data byte in frame 0x02,… -> no wr, FSM back in IDLE, and spi_miso=0.
REQ-036 SHALL verify reset mid-frame: rst_n pulsed low during a DATA byte -> all outputs take their reset values immediately, and no strobe appears until a new frame is sent.

Source files
------------

// File: rtl/spi_mmio_pkg.sv
// Shared definitions for the SPI-to-MMIO bridge: FSM states and field geometry.
package spi_mmio_pkg;

  localparam int unsigned RD_BIT      = 7;
  localparam int unsigned ADDR_W      = 7;
  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchronizer for one asynchronous input bit, with a selectable reset level.
module sync_2ff
  import spi_mmio_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {SYNC_STAGES{RST_VAL}};
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mmio_bridge.sv
// SPI mode-0 slave translating command/data frames into single-cycle MMIO read/write strobes.
module spi_mmio_bridge
  import spi_mmio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);

  state_t state, state_nxt;

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d, cs_n_d;
  logic [SYNC_STAGES-1:0] settle;
  logic armed;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr, rx_byte;
  logic [ADDR_W-1:0] addr7;
  logic rd_mode;
  logic active, sclk_rise, sclk_fall, cs_fall, byte_done;
  logic rd_set, wr_set;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s));

  always_comb begin
    active    = (state != IDLE) && !cs_n_s;
    sclk_rise = active && sclk_s && !sclk_d;
    sclk_fall = active && !sclk_s && sclk_d;
    cs_fall   = armed && cs_n_d && !cs_n_s;
    rx_byte   = {rx_sr[6:0], mosi_s};
    byte_done = sclk_rise && (bit_cnt == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cs_fall) state_nxt = CMD;
      CMD:     if (cs_n_s) state_nxt = IDLE;
               else if (byte_done) state_nxt = DATA;
      DATA:    if (cs_n_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_set   = byte_done && ((state == CMD) ? rx_byte[RD_BIT] : rd_mode);
    wr_set   = byte_done && (state == DATA) && !rd_mode;
    spi_miso = (state == IDLE) ? 1'b0 : tx_sr[7];
  end

  assign addr = {1'b0, addr7};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d  <= 1'b0;
      cs_n_d  <= 1'b1;
      settle  <= '0;
      armed   <= 1'b0;
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      addr7   <= '0;
      rd_mode <= 1'b0;
      wdata   <= '0;
      cs      <= 1'b0;
      rd      <= 1'b0;
      wr      <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
      // A frame only starts once cs_n has been seen high on settled synchronizer outputs,
      // so a frame already running when reset is released is never picked up mid-way.
      settle <= {settle[SYNC_STAGES-2:0], 1'b1};
      if (settle[SYNC_STAGES-1] && cs_n_s) armed <= 1'b1;

      rd <= rd_set;
      wr <= wr_set;
      cs <= rd_set | wr_set;

      if (!active) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
      end else begin
        if (sclk_rise) begin
          rx_sr   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        // The fall that ends a byte (count wrapped to 0) keeps the freshly loaded tx[7].
        if (rd) tx_sr <= rdata;
        else if (sclk_fall && (bit_cnt != 3'd0)) tx_sr <= {tx_sr[6:0], 1'b0};
      end

      if (byte_done) begin
        if (state == CMD) begin
          addr7   <= rx_byte[ADDR_W-1:0];
          rd_mode <= rx_byte[RD_BIT];
        end else if (rd_mode) begin
          addr7 <= addr7 + 7'd1;
        end else begin
          wdata <= rx_byte;
        end
      end
      if (wr) addr7 <= addr7 + 7'd1;
    end
  end

endmodule
